// File: rtl/mole_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mole_game_ctrl
//  Description : Parametrised whack-a-mole engine. A free-running 8-bit LFSR
//                picks the hole for each mole. Up, gap and post-hit flash
//                windows are timed in ticks of a slow enable. The engine scores
//                pad hits on the lit hole, counts expired moles and stops the
//                game once the miss limit is reached.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   1          system clock
//    rst            in   1          asynchronous, active-high reset
//    tick           in   1          one-clk enable; all windows count ticks
//    start          in   1          one-clk pulse; begins a new game (IDLE/OVER)
//    hit_pad        in   NUM_HOLES  debounced per-hole press pulses
//    mole_onehot    out  NUM_HOLES  lit hole, one-hot or all-zero
//    mole_position  out  POS_W      index of current mole (valid with mole_valid)
//    mole_valid     out  1          mole is up
//    hit_pulse      out  1          one-clk pulse on each scored hit
//    score          out  SCORE_W    hits this game, saturating
//    misses         out  MISS_W     expired moles this game
//    game_over      out  1          high while in OVER
// ----------------------------------------------------------------------------
//  Build option
//    MOLE_SPEEDUP_EN : when defined, the up window shrinks by 1/8 after every
//                      eighth scored hit, never below MIN_UP_TICKS. When not
//                      defined the up window is a constant UP_TICKS.
// ============================================================================
module mole_game_ctrl #(
    parameter int         NUM_HOLES    = 16,
    parameter int         UP_TICKS     = 8,
    parameter int         GAP_TICKS    = 4,
    parameter int         FLASH_TICKS  = 2,
    parameter int         MAX_MISSES   = 5,
    parameter int         SCORE_W      = 8,
    parameter int         MISS_W       = 4,
    parameter logic [7:0] LFSR_SEED    = 8'hA5,
    parameter int         MIN_UP_TICKS = 2,
    localparam int        POS_W        = $clog2(NUM_HOLES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 start,
    input  logic [NUM_HOLES-1:0] hit_pad,
    output logic [NUM_HOLES-1:0] mole_onehot,
    output logic [POS_W-1:0]     mole_position,
    output logic                 mole_valid,
    output logic                 hit_pulse,
    output logic [SCORE_W-1:0]   score,
    output logic [MISS_W-1:0]    misses,
    output logic                 game_over
);

    // ------------------------------------------------------------------------
    // Window counter sizing. The floor for the shrinking up window is included
    // so a floor configured above UP_TICKS still fits in the counter.
    // ------------------------------------------------------------------------
    localparam int c_max_a  = (UP_TICKS  > GAP_TICKS)    ? UP_TICKS  : GAP_TICKS;
    localparam int c_max_b  = (FLASH_TICKS > MIN_UP_TICKS) ? FLASH_TICKS : MIN_UP_TICKS;
    localparam int c_max_t  = (c_max_a > c_max_b) ? c_max_a : c_max_b;
    localparam int CNT_W    = $clog2(c_max_t + 1);

    localparam logic [CNT_W-1:0]  c_up_ticks    = CNT_W'(UP_TICKS);
    localparam logic [CNT_W-1:0]  c_gap_ticks   = CNT_W'(GAP_TICKS);
    localparam logic [CNT_W-1:0]  c_flash_ticks = CNT_W'(FLASH_TICKS);
    localparam logic [CNT_W-1:0]  c_cnt_one     = CNT_W'(1);
    localparam logic [MISS_W-1:0] c_max_misses  = MISS_W'(MAX_MISSES);
    localparam logic [SCORE_W-1:0] c_score_max  = {SCORE_W{1'b1}};

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_gap  = 3'd1;
    localparam logic [2:0] c_st_up   = 3'd2;
    localparam logic [2:0] c_st_hit  = 3'd3;
    localparam logic [2:0] c_st_over = 3'd4;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_lfsr;

    logic             w_lfsr_fb;
    logic [POS_W-1:0] w_raw_pos;
    logic [POS_W-1:0] w_pos;
    logic [NUM_HOLES-1:0] w_pos_onehot;
    logic             w_hit;
    logic             w_last_tick;
    logic             w_start_ok;
    logic [MISS_W-1:0] w_miss_inc;
    logic [CNT_W-1:0] w_up_load;

    // ------------------------------------------------------------------------
    // LFSR: x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form, shifting every clock.
    // The polynomial is primitive, so a non-zero seed never reaches zero.
    // ------------------------------------------------------------------------
    assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
        end
    end

    // ------------------------------------------------------------------------
    // Hole selection. Low LFSR bits give a value below 2^POS_W; when the hole
    // count is not a power of two a single subtraction folds the excess back
    // into range (2^POS_W < 2*NUM_HOLES guarantees one step is enough).
    // ------------------------------------------------------------------------
    assign w_raw_pos = r_lfsr[POS_W-1:0];

    generate
        if (NUM_HOLES == (1 << POS_W)) begin : g_pos_pow2
            assign w_pos = w_raw_pos;
        end else begin : g_pos_wrap
            assign w_pos = (w_raw_pos >= POS_W'(NUM_HOLES)) ?
                           (w_raw_pos - POS_W'(NUM_HOLES)) : w_raw_pos;
        end
    endgenerate

    assign w_pos_onehot = NUM_HOLES'(1) << w_pos;

    // The lit hole's one-hot mask doubles as the pad select, so only a press
    // on the current hole can register and other holes are ignored.
    assign w_hit       = (r_state == c_st_up) && (|(hit_pad & mole_onehot));
    assign w_last_tick = tick && (r_cnt == c_cnt_one);
    assign w_start_ok  = start && ((r_state == c_st_idle) || (r_state == c_st_over));
    assign w_miss_inc  = misses + MISS_W'(1);

    // ------------------------------------------------------------------------
    // Up-window length: adaptive register or fixed constant.
    // ------------------------------------------------------------------------
`ifdef MOLE_SPEEDUP_EN
    localparam logic [CNT_W-1:0] c_min_up_ticks = CNT_W'(MIN_UP_TICKS);

    logic [CNT_W-1:0] r_up_len;
    logic [CNT_W-1:0] w_up_shrunk;
    logic             w_speedup;

    assign w_up_shrunk = r_up_len - (r_up_len >> 3);
    // The hit that rolls the low three score bits over to zero triggers the
    // shrink; a saturated score no longer increments, so it cannot trigger.
    assign w_speedup   = w_hit && (score != c_score_max) && (score[2:0] == 3'b111);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_up_len <= c_up_ticks;
        end else if (w_start_ok) begin
            r_up_len <= c_up_ticks;
        end else if (w_speedup) begin
            r_up_len <= (w_up_shrunk < c_min_up_ticks) ? c_min_up_ticks : w_up_shrunk;
        end
    end

    assign w_up_load = r_up_len;
`else
    assign w_up_load = c_up_ticks;
`endif

    // ------------------------------------------------------------------------
    // Game state machine. Every timed state loads its dwell on entry,
    // decrements on tick and leaves on the tick that sees a count of one.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_cnt         <= '0;
            mole_onehot   <= '0;
            mole_position <= '0;
            mole_valid    <= 1'b0;
            hit_pulse     <= 1'b0;
            score         <= '0;
            misses        <= '0;
            game_over     <= 1'b0;
        end else begin
            hit_pulse <= 1'b0;

            case (r_state)
                c_st_idle, c_st_over: begin
                    // A start arriving together with a tick only loads the
                    // gap counter; the first decrement waits for the next tick.
                    if (w_start_ok) begin
                        score     <= '0;
                        misses    <= '0;
                        game_over <= 1'b0;
                        r_cnt     <= c_gap_ticks;
                        r_state   <= c_st_gap;
                    end
                end

                c_st_gap: begin
                    if (w_last_tick) begin
                        mole_position <= w_pos;
                        mole_onehot   <= w_pos_onehot;
                        mole_valid    <= 1'b1;
                        r_cnt         <= w_up_load;
                        r_state       <= c_st_up;
                    end else if (tick) begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end

                c_st_up: begin
                    // A hit is checked first so a press on the final tick
                    // scores instead of counting as a miss.
                    if (w_hit) begin
                        if (score != c_score_max) begin
                            score <= score + SCORE_W'(1);
                        end
                        hit_pulse   <= 1'b1;
                        mole_onehot <= '0;
                        mole_valid  <= 1'b0;
                        r_cnt       <= c_flash_ticks;
                        r_state     <= c_st_hit;
                    end else if (w_last_tick) begin
                        misses      <= w_miss_inc;
                        mole_onehot <= '0;
                        mole_valid  <= 1'b0;
                        if (w_miss_inc == c_max_misses) begin
                            game_over <= 1'b1;
                            r_state   <= c_st_over;
                        end else begin
                            r_cnt   <= c_gap_ticks;
                            r_state <= c_st_gap;
                        end
                    end else if (tick) begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end

                c_st_hit: begin
                    if (w_last_tick) begin
                        r_cnt   <= c_gap_ticks;
                        r_state <= c_st_gap;
                    end else if (tick) begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end

                default: begin
                    mole_onehot <= '0;
                    mole_valid  <= 1'b0;
                    r_state     <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mole_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mole_game_ctrl
//  Description : Directed self-checking bench for mole_game_ctrl. Instance
//                dut runs 16 holes, dut12 runs 12 holes; both use UP=4, GAP=2,
//                FLASH=1, MAX_MISSES=3 with tick high every clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mole_game_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b1;
    logic        start = 1'b0;
    logic        start12 = 1'b0;
    logic        auto12 = 1'b0;
    logic [15:0] hit_pad = 16'h0;

    logic [15:0] onehot;
    logic [3:0]  pos;
    logic        valid, hitp, over;
    logic [7:0]  score;
    logic [3:0]  misses;

    logic [11:0] hit12, onehot12;
    logic [3:0]  pos12;
    logic        valid12, hitp12, over12;
    logic [7:0]  score12;
    logic [3:0]  misses12;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_lfsr;
    logic [7:0] m_prev;
    logic [3:0] pos1 [3];
    logic [3:0] ep;

    assign hit12 = auto12 ? onehot12 : 12'd0;

    always #5 clk = ~clk;

    mole_game_ctrl #(
        .NUM_HOLES(16), .UP_TICKS(4), .GAP_TICKS(2), .FLASH_TICKS(1),
        .MAX_MISSES(3), .SCORE_W(8), .MISS_W(4), .LFSR_SEED(8'hA5), .MIN_UP_TICKS(2)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .hit_pad(hit_pad),
        .mole_onehot(onehot), .mole_position(pos), .mole_valid(valid),
        .hit_pulse(hitp), .score(score), .misses(misses), .game_over(over)
    );

    mole_game_ctrl #(
        .NUM_HOLES(12), .UP_TICKS(4), .GAP_TICKS(2), .FLASH_TICKS(1),
        .MAX_MISSES(3), .SCORE_W(8), .MISS_W(4), .LFSR_SEED(8'hA5), .MIN_UP_TICKS(2)
    ) dut12 (
        .clk(clk), .rst(rst), .tick(tick), .start(start12), .hit_pad(hit12),
        .mole_onehot(onehot12), .mole_position(pos12), .mole_valid(valid12),
        .hit_pulse(hitp12), .score(score12), .misses(misses12), .game_over(over12)
    );

    // Reference LFSR (x^8+x^6+x^5+x^4+1); m_prev holds the value seen at the
    // most recent edge, i.e. the one a mole appearing on that edge was drawn from.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lfsr <= 8'hA5;
            m_prev <= 8'hA5;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #3 rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        total++; if (onehot !== 16'h0) begin bad++; $display("FAIL rst_onehot: got %h expected 0", onehot); end
        total++; if (pos !== 4'h0)     begin bad++; $display("FAIL rst_pos: got %0d expected 0", pos); end
        total++; if (valid !== 1'b0)   begin bad++; $display("FAIL rst_valid: got %b expected 0", valid); end
        total++; if (hitp !== 1'b0)    begin bad++; $display("FAIL rst_hit_pulse: got %b expected 0", hitp); end
        total++; if (score !== 8'h0)   begin bad++; $display("FAIL rst_score: got %0d expected 0", score); end
        total++; if (misses !== 4'h0)  begin bad++; $display("FAIL rst_misses: got %0d expected 0", misses); end
        total++; if (over !== 1'b0)    begin bad++; $display("FAIL rst_game_over: got %b expected 0", over); end
        release_reset();
    endtask

    // Three moles expire untouched; repro=1 also demands the same holes as the
    // first game after reset.
    task automatic test_no_press(input bit repro);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int m = 0; m < 3; m++) begin
            step();
            total++; if (valid !== 1'b0) begin bad++; $display("FAIL gap_dark m=%0d: got %b expected 0", m, valid); end
            step();
            total++; if (valid !== 1'b1) begin bad++; $display("FAIL mole_up m=%0d: got %b expected 1", m, valid); end
            ep = m_prev[3:0];
            total++; if (pos !== ep) begin bad++; $display("FAIL mole_pos m=%0d: got %0d expected %0d", m, pos, ep); end
            total++; if (onehot !== (16'd1 << ep)) begin bad++; $display("FAIL mole_onehot m=%0d: got %h expected %h", m, onehot, 16'd1 << ep); end
            if (repro) begin
                total++; if (pos !== pos1[m]) begin bad++; $display("FAIL repro_pos m=%0d: got %0d expected %0d", m, pos, pos1[m]); end
            end else begin
                pos1[m] = ep;
            end
            for (int k = 1; k < 4; k++) begin
                step();
                total++; if (valid !== 1'b1) begin bad++; $display("FAIL mole_hold m=%0d k=%0d: got %b expected 1", m, k, valid); end
            end
            step();
            total++; if (valid !== 1'b0) begin bad++; $display("FAIL expire_dark m=%0d: got %b expected 0", m, valid); end
            total++; if (misses !== 4'(m + 1)) begin bad++; $display("FAIL miss_count m=%0d: got %0d expected %0d", m, misses, m + 1); end
            total++; if (score !== 8'h0) begin bad++; $display("FAIL no_press_score m=%0d: got %0d expected 0", m, score); end
            total++; if (over !== (m == 2)) begin bad++; $display("FAIL game_over m=%0d: got %b expected %b", m, over, (m == 2)); end
        end
        step();
        total++; if (over !== 1'b1 || valid !== 1'b0) begin bad++; $display("FAIL over_hold: got over=%b valid=%b expected 1 0", over, valid); end
    endtask

    task automatic test_hit();
        start = 1'b1;
        step();
        start = 1'b0;
        total++; if (over !== 1'b0 || misses !== 4'h0 || score !== 8'h0) begin
            bad++; $display("FAIL restart_clear: got over=%b misses=%0d score=%0d expected 0 0 0", over, misses, score);
        end
        step();
        step();
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL hit_mole_up: got %b expected 1", valid); end
        ep = m_prev[3:0];
        step();
        hit_pad = 16'd1 << ep;
        step();
        hit_pad = 16'h0;
        total++; if (hitp !== 1'b1) begin bad++; $display("FAIL hit_pulse_on: got %b expected 1", hitp); end
        total++; if (score !== 8'd1) begin bad++; $display("FAIL hit_score: got %0d expected 1", score); end
        total++; if (valid !== 1'b0 || onehot !== 16'h0) begin bad++; $display("FAIL hit_clear: got valid=%b onehot=%h expected 0 0", valid, onehot); end
        step();
        total++; if (hitp !== 1'b0) begin bad++; $display("FAIL hit_pulse_off: got %b expected 0", hitp); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL flash_dark: got %b expected 0", valid); end
        step();
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL regap_dark: got %b expected 0", valid); end
        step();
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL reappear: got %b expected 1", valid); end
        ep = m_prev[3:0];
        total++; if (pos !== ep) begin bad++; $display("FAIL reappear_pos: got %0d expected %0d", pos, ep); end
    endtask

    // Mole is up (first UP clock). Every other hole is pressed and a start is
    // pulsed; neither may disturb the mole or the score.
    task automatic test_wrong_hole();
        hit_pad = ~(16'd1 << ep);
        start = 1'b1;
        step();
        start = 1'b0;
        total++; if (valid !== 1'b1 || score !== 8'd1) begin bad++; $display("FAIL wrong_hole_ignored: got valid=%b score=%0d expected 1 1", valid, score); end
        step();
        step();
        total++; if (valid !== 1'b1 || hitp !== 1'b0) begin bad++; $display("FAIL wrong_hole_hold: got valid=%b hit=%b expected 1 0", valid, hitp); end
        step();
        hit_pad = 16'h0;
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL wrong_hole_expire: got %b expected 0", valid); end
        total++; if (misses !== 4'd1 || score !== 8'd1) begin bad++; $display("FAIL wrong_hole_counts: got misses=%0d score=%0d expected 1 1", misses, score); end
    endtask

    task automatic test_hit_last_tick();
        step();
        step();
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL last_mole_up: got %b expected 1", valid); end
        ep = m_prev[3:0];
        step();
        step();
        step();
        hit_pad = 16'd1 << ep;
        step();
        hit_pad = 16'h0;
        total++; if (hitp !== 1'b1 || score !== 8'd2) begin bad++; $display("FAIL last_tick_hit: got hit=%b score=%0d expected 1 2", hitp, score); end
        total++; if (misses !== 4'd1) begin bad++; $display("FAIL last_tick_no_miss: got %0d expected 1", misses); end
        step();
        step();
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL last_tick_flash: got %b expected 0", valid); end
        step();
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL last_tick_reappear: got %b expected 1", valid); end
    endtask

    task automatic test_async_reset();
        #3 rst = 1'b1;
        #1;
        total++; if (onehot !== 16'h0 || valid !== 1'b0 || pos !== 4'h0) begin
            bad++; $display("FAIL async_rst_mole: got onehot=%h valid=%b pos=%0d expected 0 0 0", onehot, valid, pos);
        end
        total++; if (score !== 8'h0 || misses !== 4'h0 || over !== 1'b0 || hitp !== 1'b0) begin
            bad++; $display("FAIL async_rst_counts: got score=%0d misses=%0d over=%b hit=%b expected 0 0 0 0", score, misses, over, hitp);
        end
        release_reset();
        test_no_press(1'b1);
    endtask

    task automatic test_saturate12();
        int hc;
        int moles;
        int cyc;
        int es;
        logic pv;
        logic [3:0] p;
        hc = 0; moles = 0; cyc = 0; pv = 1'b0;
        start12 = 1'b1;
        step();
        start12 = 1'b0;
        auto12 = 1'b1;
        while (moles < 1000 && cyc < 8000) begin
            step();
            cyc++;
            if (hitp12) hc++;
            if (valid12 && !pv) begin
                moles++;
                p = m_prev[3:0];
                if (p >= 4'd12) p = p - 4'd12;
                total++; if (pos12 !== p) begin bad++; $display("FAIL h12_pos mole=%0d: got %0d expected %0d", moles, pos12, p); end
            end
            total++; if (onehot12 !== (valid12 ? (12'd1 << pos12) : 12'd0)) begin
                bad++; $display("FAIL h12_invariant cyc=%0d: got %h expected valid=%b pos=%0d", cyc, onehot12, valid12, pos12);
            end
            es = (hc > 255) ? 255 : hc;
            total++; if (score12 !== 8'(es)) begin bad++; $display("FAIL h12_score cyc=%0d: got %0d expected %0d", cyc, score12, es); end
            pv = valid12;
        end
        step();
        if (hitp12) hc++;
        step();
        if (hitp12) hc++;
        auto12 = 1'b0;
        total++; if (moles != 1000) begin bad++; $display("FAIL h12_budget: got %0d moles expected 1000", moles); end
        total++; if (hc != 1000) begin bad++; $display("FAIL h12_hits: got %0d expected 1000", hc); end
        total++; if (score12 !== 8'd255) begin bad++; $display("FAIL h12_saturate: got %0d expected 255", score12); end
        total++; if (misses12 !== 4'd0 || over12 !== 1'b0) begin bad++; $display("FAIL h12_misses: got misses=%0d over=%b expected 0 0", misses12, over12); end
    endtask

    initial begin
        test_reset();
        test_no_press(1'b0);
        test_hit();
        test_wrong_hole();
        test_hit_last_tick();
        test_async_reset();
        test_saturate12();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/mole_game_ctrl.md
Name: mole_game_ctrl

Overview:
- Parametrised whack-a-mole engine: the successor to the fixed 16-hole position decoder.
- Picks pseudo-random hole positions and times the mole's up/gap windows from a slow tick.
- Detects hits from a pad vector, keeps score and miss count, and ends the game after a miss limit.
- Drives the LED matrix (one-hot) and the score display logic directly.

Parameters:
- NUM_HOLES, 16: hole count; legal range 2..32.
- POS_W, derived localparam = clog2(NUM_HOLES): position width.
- UP_TICKS, 8: ticks the mole stays up; ≥1.
- GAP_TICKS, 4: ticks between moles; ≥1.
- FLASH_TICKS, 2: ticks of blank after a hit; ≥1.
- MAX_MISSES, 5: misses that end the game; ≥1, fits in MISS_W.
- SCORE_W, 8: score width.
- MISS_W, 4: miss counter width.
- LFSR_SEED, 8'hA5: LFSR reset value; must be non-zero.
- MIN_UP_TICKS, 2: floor for the up window; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- tick  in  1  one-clk enable pulse; all window timing counts ticks
- start  in  1  one-clk pulse; begins a new game
- hit_pad  in  NUM_HOLES  per-hole press pulses, already debounced
- mole_onehot  out  NUM_HOLES  lit hole, one-hot or all-zero
- mole_position  out  POS_W  index of current mole; valid only when mole_valid=1
- mole_valid  out  1  mole is up
- hit_pulse  out  1  one-clk pulse on each scored hit
- score  out  SCORE_W  hits this game; saturates at all-ones
- misses  out  MISS_W  expired moles this game
- game_over  out  1  high in OVER state

Behaviour:
- Reset (async, immediate, usable mid-game):
  - state IDLE.
  - mole_onehot=0, mole_position=0, mole_valid=0, hit_pulse=0, score=0, misses=0, game_over=0.
  - lfsr=LFSR_SEED; tick counter=0.
- States: IDLE, GAP, UP, HIT, OVER. All outputs are registered.
- Dwell: each timed state loads its counter with N on entry, decrements on tick, and exits on the tick where counter==1. Dwell is exactly N ticks.
- IDLE/OVER: start → clear score, misses and game_over, then enter GAP. start is ignored in GAP/UP/HIT.
- GAP: on exit, pos = lfsr[POS_W-1:0]; if pos ≥ NUM_HOLES, pos -= NUM_HOLES. Register mole_position=pos, mole_onehot=1<<pos, mole_valid=1, then enter UP.
- UP:
  - hit_pad is sampled every clk, not gated by tick.
  - If hit_pad[mole_position]=1: score+1 (saturating), hit_pulse=1 for one clk, mole cleared (onehot 0, valid 0) at the same edge, enter HIT.
  - Presses on other holes are ignored.
  - On expiry without a hit: misses+1 and mole cleared. If new misses == MAX_MISSES, enter OVER; otherwise enter GAP.
  - Hit and expiry on the same clk: the hit wins; no miss is counted.
- HIT: mole dark for FLASH_TICKS, then enter GAP.
- OVER: game_over=1, mole dark, score and misses held until start.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifts every clk in every state. It never reaches zero.
- Invariant: mole_onehot == (mole_valid ? 1<<mole_position : 0) on every cycle.
- tick and start asserted on the same clk in IDLE: start is taken; the GAP counter is loaded, not decremented.

Optional Feature:
- Macro: MOLE_SPEEDUP_EN.
- Defined:
  - Register up_len is loaded to UP_TICKS on start; UP loads up_len instead of UP_TICKS.
  - On each scored hit that makes score[2:0]==0: up_len -= up_len>>3, floored at MIN_UP_TICKS.
  - Saturated score does not trigger further speedup.
- Undefined: the up window is constant UP_TICKS; MIN_UP_TICKS is unused and no up_len register exists.

Test Plan:
(Common setup unless stated: NUM_HOLES=16, UP_TICKS=4, GAP_TICKS=2, FLASH_TICKS=1, MAX_MISSES=3, tick high every clk.)
- No presses: reset, then start → mole_valid rises 2 clk after GAP entry and lasts 4 clk. misses goes 1, 2, 3; game_over=1 after the 3rd miss; score stays 0.
- Correct press on the 2nd UP clk → hit_pulse high exactly 1 clk, score=1, mole_onehot=0 the next clk; mole reappears 1+2 ticks later.
- Press on a wrong hole only → score=0 and state unchanged; the mole expires and misses=1.
- Correct press on the same clk as the last UP tick → score=1, misses=0, next state HIT.
- NUM_HOLES=12, auto-hit every mole for 1000 moles → every mole_position <12, onehot invariant holds, score saturates at 255 with no wrap.
- rst asserted mid-UP, asynchronous to clk → all outputs at reset values before the next edge. After release, start reproduces the position sequence from LFSR_SEED.
